// File: rtl/vote_tally_fsm_if.sv
// rtl/vote_tally_fsm_if.sv - ballot control and result bus for vote_tally_fsm
//
// Purpose: bundles the per-voter vote strobes and the registered ballot result.
// Ports (signals):
//   start       opens a ballot (honoured only when the tally is idle or done)
//   vote_valid  per-voter vote strobe
//   vote_yes    per-voter vote value when strobed (1 = yes, 0 = no)
//   busy        ballot window open or decision pending
//   done        one-cycle pulse when a new result is valid
//   result      [2] win, [1] tie, [0] lose; 000 when quorum is missed
//   no_quorum   last ballot had fewer votes than the quorum
//   yes_cnt     yes votes in the current/last ballot
//   no_cnt      no votes in the current/last ballot
//   voted       voters that have voted in this ballot
// Modports: master drives votes and start, slave is the tally block.
interface vote_tally_fsm_if #(
   parameter int N_VOTERS = 4
);
   localparam int CW = $clog2(N_VOTERS + 1);

   logic                start;
   logic [N_VOTERS-1:0] vote_valid;
   logic [N_VOTERS-1:0] vote_yes;
   logic                busy;
   logic                done;
   logic [2:0]          result;
   logic                no_quorum;
   logic [CW-1:0]       yes_cnt;
   logic [CW-1:0]       no_cnt;
   logic [N_VOTERS-1:0] voted;

   modport master (
      output start, vote_valid, vote_yes,
      input  busy, done, result, no_quorum, yes_cnt, no_cnt, voted
   );

   modport slave (
      input  start, vote_valid, vote_yes,
      output busy, done, result, no_quorum, yes_cnt, no_cnt, voted
   );
endinterface

// File: rtl/vote_tally_fsm.sv
// rtl/vote_tally_fsm.sv - clocked ballot tally with timeout, quorum and chair tie-break
//
// Purpose: opens a ballot window on start, accepts one vote per voter until
// everyone has voted or the window times out, then registers a one-hot
// win/tie/lose decision and holds it until the next ballot.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    vote_tally_fsm_if.slave (start, vote_valid, vote_yes in;
//          busy, done, result, no_quorum, yes_cnt, no_cnt, voted out)
module vote_tally_fsm #(
   parameter int N_VOTERS  = 4,
   parameter int TIMEOUT   = 16,
   parameter int QUORUM    = 1,
   parameter int TIE_BREAK = 0
) (
   input logic             clk,
   input logic             rst_n,
   vote_tally_fsm_if.slave bus
);
   localparam int CW = $clog2(N_VOTERS + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [CW:0]   QUORUM_W   = (CW + 1)'(QUORUM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DECIDE,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [N_VOTERS-1:0] voted_q;
   logic [N_VOTERS-1:0] accept;
   logic [N_VOTERS-1:0] voted_nxt;
   logic [CW-1:0]       yes_q;
   logic [CW-1:0]       no_q;
   logic [CW-1:0]       add_yes;
   logic [CW-1:0]       add_no;
   logic [TW-1:0]       timer_q;
   logic                v0_yes_q;
   logic [2:0]          result_q;
   logic                nq_q;
   logic                done_q;
   logic                clear;
   logic                decide;
   logic [2:0]          dec_result;
   logic                dec_nq;
   logic [CW:0]         total;

   // First vote is final: only strobes from voters not yet in the mask count,
   // and only while the window is open.
   always_comb begin
      accept  = '0;
      add_yes = '0;
      add_no  = '0;
      if (state == S_COLLECT) begin
         accept = bus.vote_valid & ~voted_q;
      end
      for (int i = 0; i < N_VOTERS; i++) begin
         if (accept[i]) begin
            if (bus.vote_yes[i]) begin
               add_yes = add_yes + CW'(1);
            end else begin
               add_no = add_no + CW'(1);
            end
         end
      end
      voted_nxt = voted_q | accept;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The window closes on the mask that includes this cycle's votes, so a
   // full turnout in one cycle goes straight to DECIDE.
   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      decide    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_nxt = S_COLLECT;
               clear     = 1'b1;
            end
         end
         S_COLLECT: begin
            if ((&voted_nxt) || (timer_q == TIMER_LAST)) begin
               state_nxt = S_DECIDE;
            end
         end
         S_DECIDE: begin
            state_nxt = S_DONE;
            decide    = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Decision from the final counts; the tie-break needs voter 0 to have
   // actually voted, otherwise an abstaining chair leaves a plain tie.
   always_comb begin
      dec_result = 3'b000;
      dec_nq     = 1'b0;
      total      = {1'b0, yes_q} + {1'b0, no_q};
      if (total < QUORUM_W) begin
         dec_nq = 1'b1;
      end else if (yes_q > no_q) begin
         dec_result = 3'b100;
      end else if (yes_q < no_q) begin
         dec_result = 3'b001;
      end else if ((TIE_BREAK != 0) && voted_q[0]) begin
         dec_result = v0_yes_q ? 3'b100 : 3'b001;
      end else begin
         dec_result = 3'b010;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         voted_q  <= '0;
         yes_q    <= '0;
         no_q     <= '0;
         timer_q  <= '0;
         v0_yes_q <= 1'b0;
         result_q <= 3'b000;
         nq_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= decide;
         if (clear) begin
            // result/no_quorum keep showing the previous ballot until decided
            voted_q  <= '0;
            yes_q    <= '0;
            no_q     <= '0;
            timer_q  <= '0;
            v0_yes_q <= 1'b0;
         end else if (state == S_COLLECT) begin
            voted_q <= voted_nxt;
            yes_q   <= yes_q + add_yes;
            no_q    <= no_q + add_no;
            timer_q <= timer_q + TW'(1);
            if (accept[0]) begin
               v0_yes_q <= bus.vote_yes[0];
            end
         end
         if (decide) begin
            result_q <= dec_result;
            nq_q     <= dec_nq;
         end
      end
   end

   assign bus.busy      = (state == S_COLLECT) || (state == S_DECIDE);
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.no_quorum = nq_q;
   assign bus.yes_cnt   = yes_q;
   assign bus.no_cnt    = no_q;
   assign bus.voted     = voted_q;
endmodule

// File: tb/tb_vote_tally_fsm.sv
// tb/tb_vote_tally_fsm.sv - scoreboard bench for vote_tally_fsm over three configurations
module tb_vote_tally_fsm;
   localparam int NV   = 4;
   localparam int TMO  = 16;
   localparam int MAXC = TMO + 3;

   typedef struct {
      logic [2:0] res;
      logic       nq;
      int         yes;
      int         no;
      logic [3:0] voted;
      int         kend;
      int         start_cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   logic start;
   logic [NV-1:0] vote_valid;
   logic [NV-1:0] vote_yes;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   logic [NV-1:0] s_vv [0:MAXC];
   logic [NV-1:0] s_vy [0:MAXC];
   bit            s_st [0:MAXC];

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   vote_tally_fsm_if #(.N_VOTERS(NV)) if_a ();
   vote_tally_fsm_if #(.N_VOTERS(NV)) if_b ();
   vote_tally_fsm_if #(.N_VOTERS(NV)) if_c ();

   assign if_a.start = start;
   assign if_a.vote_valid = vote_valid;
   assign if_a.vote_yes = vote_yes;
   assign if_b.start = start;
   assign if_b.vote_valid = vote_valid;
   assign if_b.vote_yes = vote_yes;
   assign if_c.start = start;
   assign if_c.vote_valid = vote_valid;
   assign if_c.vote_yes = vote_yes;

   vote_tally_fsm #(.N_VOTERS(NV), .TIMEOUT(TMO), .QUORUM(1), .TIE_BREAK(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a));
   vote_tally_fsm #(.N_VOTERS(NV), .TIMEOUT(TMO), .QUORUM(1), .TIE_BREAK(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b));
   vote_tally_fsm #(.N_VOTERS(NV), .TIMEOUT(TMO), .QUORUM(3), .TIE_BREAK(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(if_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: walk the ballot cycle by cycle, first vote per voter wins,
   // window ends at TMO cycles or full turnout; 'upto' gives a prefix.
   function automatic exp_t model(input int quorum, input bit tbrk, input int upto);
      exp_t e;
      bit   v0 = 1'b0;
      e.yes = 0;
      e.no = 0;
      e.voted = '0;
      e.kend = TMO;
      e.start_cyc = 0;
      for (int k = 1; k <= TMO; k++) begin
         if (k > upto) break;
         for (int i = 0; i < NV; i++) begin
            if (s_vv[k][i] && !e.voted[i]) begin
               e.voted[i] = 1'b1;
               if (s_vy[k][i]) e.yes++;
               else e.no++;
               if (i == 0) v0 = s_vy[k][i];
            end
         end
         if (e.voted == 4'hF) begin
            e.kend = k;
            break;
         end
      end
      e.nq = 1'b0;
      if (e.yes + e.no < quorum) begin
         e.res = 3'b000;
         e.nq = 1'b1;
      end else if (e.yes > e.no) e.res = 3'b100;
      else if (e.yes < e.no) e.res = 3'b001;
      else if (tbrk && e.voted[0]) e.res = v0 ? 3'b100 : 3'b001;
      else e.res = 3'b010;
      return e;
   endfunction

   task automatic check_done(input string tag, input exp_t e, input int res, input int nq,
                             input int y, input int n, input int vt, input int bsy);
      chk({tag, ".result"}, res, int'(e.res));
      chk({tag, ".no_quorum"}, nq, int'(e.nq));
      chk({tag, ".yes_cnt"}, y, e.yes);
      chk({tag, ".no_cnt"}, n, e.no);
      chk({tag, ".voted"}, vt, int'(e.voted));
      chk({tag, ".busy_at_done"}, bsy, 0);
      if (e.voted == 4'hF) chk({tag, ".latency"}, cyc - e.start_cyc, e.kend + 1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && if_a.done) begin
         if (q_a.size() == 0) chk("a.spurious_done", 1, 0);
         else begin
            e = q_a.pop_front();
            check_done("a", e, int'(if_a.result), int'(if_a.no_quorum), int'(if_a.yes_cnt),
                       int'(if_a.no_cnt), int'(if_a.voted), int'(if_a.busy));
         end
      end
      if (rst_n && if_b.done) begin
         if (q_b.size() == 0) chk("b.spurious_done", 1, 0);
         else begin
            e = q_b.pop_front();
            check_done("b", e, int'(if_b.result), int'(if_b.no_quorum), int'(if_b.yes_cnt),
                       int'(if_b.no_cnt), int'(if_b.voted), int'(if_b.busy));
         end
      end
      if (rst_n && if_c.done) begin
         if (q_c.size() == 0) chk("c.spurious_done", 1, 0);
         else begin
            e = q_c.pop_front();
            check_done("c", e, int'(if_c.result), int'(if_c.no_quorum), int'(if_c.yes_cnt),
                       int'(if_c.no_cnt), int'(if_c.voted), int'(if_c.busy));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, ".a"}, int'({if_a.busy, if_a.done, if_a.result, if_a.no_quorum,
                             if_a.yes_cnt, if_a.no_cnt, if_a.voted}), 0);
      chk({tag, ".b"}, int'({if_b.busy, if_b.done, if_b.result, if_b.no_quorum,
                             if_b.yes_cnt, if_b.no_cnt, if_b.voted}), 0);
      chk({tag, ".c"}, int'({if_c.busy, if_c.done, if_c.result, if_c.no_quorum,
                             if_c.yes_cnt, if_c.no_cnt, if_c.voted}), 0);
   endtask

   task automatic clear_stim();
      for (int k = 0; k <= MAXC; k++) begin
         s_vv[k] = '0;
         s_vy[k] = '0;
         s_st[k] = 1'b0;
      end
   endtask

   task automatic run_ballot();
      exp_t ea, eb, ec, p;
      int   bound;
      ea = model(1, 1'b0, TMO);
      eb = model(1, 1'b1, TMO);
      ec = model(3, 1'b0, TMO);
      @(negedge clk);
      start = 1'b1;
      vote_valid = s_vv[0];
      vote_yes = s_vy[0];
      @(posedge clk);
      @(negedge clk);
      ea.start_cyc = cyc;
      eb.start_cyc = cyc;
      ec.start_cyc = cyc;
      q_a.push_back(ea);
      q_b.push_back(eb);
      q_c.push_back(ec);
      chk("busy_after_start", int'(if_a.busy), 1);
      for (int k = 1; k <= MAXC; k++) begin
         // start only while busy, so it must be ignored
         start = (k <= ea.kend + 1) ? s_st[k] : 1'b0;
         vote_valid = s_vv[k];
         vote_yes = s_vy[k];
         @(posedge clk);
         @(negedge clk);
         if (k <= ea.kend) begin
            p = model(1, 1'b0, k);
            chk("live_yes_cnt", int'(if_a.yes_cnt), p.yes);
            chk("live_no_cnt", int'(if_a.no_cnt), p.no);
            chk("live_voted", int'(if_a.voted), int'(p.voted));
            chk("live_busy", int'(if_a.busy), 1);
         end
      end
      start = 1'b0;
      vote_valid = '0;
      vote_yes = '0;
      bound = 0;
      while ((q_a.size() + q_b.size() + q_c.size()) != 0 && bound < 40) begin
         @(negedge clk);
         bound++;
      end
      if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
         chk("done_not_seen", q_a.size() + q_b.size() + q_c.size(), 0);
         q_a.delete();
         q_b.delete();
         q_c.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      vote_valid = '0;
      vote_yes = '0;
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // strobes in IDLE are ignored
      vote_valid = 4'hF;
      vote_yes = 4'hF;
      repeat (3) @(negedge clk);
      check_all_zero("idle_strobe");
      vote_valid = '0;
      vote_yes = '0;

      // full turnout in the first cycle
      clear_stim();
      s_vv[1] = 4'b1111;
      s_vy[1] = 4'b0111;
      run_ballot();

      // duplicate vote from voter 1 is ignored
      clear_stim();
      s_vv[1] = 4'b0010; s_vy[1] = 4'b0010;
      s_vv[2] = 4'b0010; s_vy[2] = 4'b0000;
      s_vv[3] = 4'b1101; s_vy[3] = 4'b0000;
      run_ballot();

      // reset mid-COLLECT after two votes
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vote_valid = 4'b0011;
      vote_yes = 4'b0001;
      @(negedge clk);
      vote_valid = '0;
      vote_yes = '0;
      chk("pre_reset_yes", int'(if_a.yes_cnt), 1);
      chk("pre_reset_result", int'(if_a.result), 3'b001);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // timeout tie, with a start pulse during busy
      clear_stim();
      s_vv[1] = 4'b0011;
      s_vy[1] = 4'b0001;
      s_st[5] = 1'b1;
      run_ballot();

      // nobody votes
      clear_stim();
      s_st[10] = 1'b1;
      run_ballot();

      for (int b = 0; b < 24; b++) begin
         for (int k = 0; k <= MAXC; k++) begin
            s_vv[k] = 4'($urandom & $urandom);
            s_vy[k] = 4'($urandom);
            s_st[k] = ($urandom_range(0, 7) == 0);
         end
         run_ballot();
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
